// File: rtl/huffman_decoder.sv
// Serial Huffman decoder. It loads a 6-entry code table, shifts in bits MSB-first and
// emits the index of each completed codeword over a valid/ready handshake.
module huffman_decoder #(
  parameter int CODE_W = 8,
  parameter int SYM_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              sym_valid,
  output logic [SYM_W-1:0]  sym_data,
  input  logic              sym_ready,
  output logic              code_err,
  output logic [7:0]        sym_cnt
);

  localparam int LEN_W = $clog2(CODE_W + 1);
  localparam int NSYM  = 6;

  typedef enum logic [1:0] {ST_EMPTY, ST_RUN, ST_OUT, ST_ERR} state_t;

  function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] v);
    logic [LEN_W-1:0] c;
    c = '0;
    for (int i = 0; i < CODE_W; i++) begin
      c = c + LEN_W'(v[i]);
    end
    return c;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [CODE_W-1:0]  hc_r [NSYM];
  logic [CODE_W-1:0]  m_r  [NSYM];
  logic [LEN_W-1:0]   l_r  [NSYM];
  logic [CODE_W-1:0]  hc_in_s [NSYM];
  logic [CODE_W-1:0]  m_in_s  [NSYM];
  logic [CODE_W-1:0]  shreg_r, shn_s;
  logic [LEN_W-1:0]   len_r, lenn_s;
  logic               hit_s;
  logic [SYM_W-1:0]   hit_idx_s;

  // Gather the table ports into arrays so loading and matching can loop.
  always_comb begin
    hc_in_s = '{HC1, HC2, HC3, HC4, HC5, HC6};
    m_in_s  = '{M1, M2, M3, M4, M5, M6};
  end

  // Candidate shift state and table match; scanning downward lets the lowest index win.
  always_comb begin
    shn_s     = {shreg_r[CODE_W-2:0], bit_in};
    lenn_s    = len_r + LEN_W'(1);
    hit_s     = 1'b0;
    hit_idx_s = {SYM_W{1'b0}};
    for (int n = NSYM - 1; n >= 0; n--) begin
      if ((l_r[n] != '0) && (lenn_s == l_r[n]) && ((shn_s & m_r[n]) == hc_r[n])) begin
        hit_s     = 1'b1;
        hit_idx_s = SYM_W'(n + 1);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  // Next-state logic; a table load overrides everything else.
  always_comb begin
    state_nxt_s = state_r;
    if (code_valid) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_EMPTY: state_nxt_s = ST_EMPTY;
        ST_RUN: begin
          if (bit_valid && hit_s) begin
            state_nxt_s = ST_OUT;
          end else if (bit_valid && (lenn_s == LEN_W'(CODE_W))) begin
            state_nxt_s = ST_ERR;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_OUT: begin
          if (sym_ready) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_OUT;
          end
        end
        ST_ERR:  state_nxt_s = ST_ERR;
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // State register, table storage, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_EMPTY;
      bit_ready <= 1'b0;
      sym_valid <= 1'b0;
      sym_data  <= {SYM_W{1'b0}};
      code_err  <= 1'b0;
      sym_cnt   <= 8'd0;
      shreg_r   <= {CODE_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      for (int n = 0; n < NSYM; n++) begin
        hc_r[n] <= {CODE_W{1'b0}};
        m_r[n]  <= {CODE_W{1'b0}};
        l_r[n]  <= {LEN_W{1'b0}};
      end
    end else begin
      state_r   <= state_nxt_s;
      bit_ready <= (state_nxt_s == ST_RUN);
      if (code_valid) begin
        for (int n = 0; n < NSYM; n++) begin
          hc_r[n] <= hc_in_s[n];
          m_r[n]  <= m_in_s[n];
          l_r[n]  <= popcount(m_in_s[n]);
        end
        shreg_r   <= {CODE_W{1'b0}};
        len_r     <= {LEN_W{1'b0}};
        sym_valid <= 1'b0;
        code_err  <= 1'b0;
        sym_cnt   <= 8'd0;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (bit_valid && hit_s) begin
              sym_data  <= hit_idx_s;
              sym_valid <= 1'b1;
              shreg_r   <= {CODE_W{1'b0}};
              len_r     <= {LEN_W{1'b0}};
            end else if (bit_valid && (lenn_s == LEN_W'(CODE_W))) begin
              code_err <= 1'b1;
            end else if (bit_valid) begin
              shreg_r <= shn_s;
              len_r   <= lenn_s;
            end else begin
              shreg_r <= shreg_r;
            end
          end
          ST_OUT: begin
            if (sym_ready) begin
              sym_valid <= 1'b0;
              sym_cnt   <= sym_cnt + 8'd1;
            end else begin
              sym_valid <= 1'b1;
            end
          end
          default: sym_valid <= sym_valid;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed testbench for huffman_decoder: reset, decoding, backpressure, error,
// mid-codeword reload and symbol counter wrap.
module tb_huffman_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] hc [6];
  logic [7:0] m  [6];
  logic       bit_valid, bit_in, bit_ready;
  logic       sym_valid, sym_ready, code_err;
  logic [2:0] sym_data;
  logic [7:0] sym_cnt;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  huffman_decoder #(.CODE_W(8), .SYM_W(3)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .code_err(code_err), .sym_cnt(sym_cnt)
  );

  // Present the reference table for one cycle; optionally drive a bit in the same cycle.
  task automatic load_table(input logic m6_en, input logic with_bit);
    hc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
    m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, (m6_en ? 8'h1F : 8'h00)};
    code_valid = 1'b1;
    bit_valid  = with_bit;
    bit_in     = 1'b0;
    @(negedge clk);
    code_valid = 1'b0;
    bit_valid  = 1'b0;
  endtask

  // Drive one bit once the decoder is ready; returns at the negedge after acceptance.
  task automatic send_bit(input logic b);
    for (int k = 0; k < 20 && !bit_ready; k++) @(negedge clk);
    if (!bit_ready) begin
      checks++;
      errors++;
      $display("FAIL send_bit_timeout: bit_ready=%0b required 1", bit_ready);
    end
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bit_ready, sym_valid, sym_data, code_err, sym_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b v=%0b d=%0d err=%0b cnt=%0d required all 0",
               bit_ready, sym_valid, sym_data, code_err, sym_cnt);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bit_ready, sym_valid, code_err, sym_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL empty_ignores_bits: got rdy=%0b v=%0b err=%0b cnt=%0d required all 0",
               bit_ready, sym_valid, code_err, sym_cnt);
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_decode();
    logic       bits [8];
    logic       exp_v [8];
    logic [2:0] exp_d [8];
    bits  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_d = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6};
    sym_ready = 1'b1;
    load_table(1'b1, 1'b0);
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready: got %0b required 1", bit_ready);
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[i]);
      checks++;
      if (sym_valid !== exp_v[i] || (exp_v[i] && sym_data !== exp_d[i])) begin
        errors++;
        $display("FAIL decode_bit%0d: got v=%0b d=%0d required v=%0b d=%0d",
                 i, sym_valid, sym_data, exp_v[i], exp_d[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (sym_cnt !== 8'd3 || sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_cnt: got cnt=%0d v=%0b required cnt=3 v=0", sym_cnt, sym_valid);
    end
  endtask

  task automatic test_backpressure();
    sym_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sym_valid !== 1'b1 || sym_data !== 3'd3 || bit_ready !== 1'b0 || sym_cnt !== 8'd3) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%0b d=%0d rdy=%0b cnt=%0d required v=1 d=3 rdy=0 cnt=3",
                 i, sym_valid, sym_data, bit_ready, sym_cnt);
      end
      @(negedge clk);
    end
    sym_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (sym_valid !== 1'b0 || sym_cnt !== 8'd4 || bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%0b cnt=%0d rdy=%0b required v=0 cnt=4 rdy=1",
               sym_valid, sym_cnt, bit_ready);
    end
  endtask

  task automatic test_error();
    load_table(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      checks++;
      if (sym_valid !== 1'b0 || code_err !== (i == 7)) begin
        errors++;
        $display("FAIL err_bit%0d: got v=%0b err=%0b required v=0 err=%0b",
                 i, sym_valid, code_err, (i == 7));
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (code_err !== 1'b1 || bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got err=%0b rdy=%0b required err=1 rdy=0", code_err, bit_ready);
    end
    load_table(1'b1, 1'b0);
    checks++;
    if (code_err !== 1'b0 || bit_ready !== 1'b1 || sym_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_reload: got err=%0b rdy=%0b cnt=%0d required err=0 rdy=1 cnt=0",
               code_err, bit_ready, sym_cnt);
    end
  endtask

  task automatic test_reload_mid();
    send_bit(1'b1); send_bit(1'b1);
    load_table(1'b1, 1'b0);
    checks++;
    if (sym_valid !== 1'b0 || bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_mid: got v=%0b rdy=%0b required v=0 rdy=1", sym_valid, bit_ready);
    end
    send_bit(1'b0);
    checks++;
    if (sym_valid !== 1'b1 || sym_data !== 3'd1) begin
      errors++;
      $display("FAIL reload_sym: got v=%0b d=%0d required v=1 d=1", sym_valid, sym_data);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    load_table(1'b1, 1'b0);
    for (int i = 0; i < 257; i++) begin
      send_bit(1'b0);
      @(negedge clk);
      if (i == 254 || i == 255 || i == 256) begin
        checks++;
        if (sym_cnt !== 8'((i + 1) % 256)) begin
          errors++;
          $display("FAIL wrap_cnt%0d: got %0d required %0d", i, sym_cnt, (i + 1) % 256);
        end
      end
    end
    load_table(1'b1, 1'b1);
    checks++;
    if (sym_valid !== 1'b0 || sym_cnt !== 8'd0 || bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_drops_bit: got v=%0b cnt=%0d rdy=%0b required v=0 cnt=0 rdy=1",
               sym_valid, sym_cnt, bit_ready);
    end
    send_bit(1'b0);
    checks++;
    if (sym_valid !== 1'b1 || sym_data !== 3'd1) begin
      errors++;
      $display("FAIL after_load: got v=%0b d=%0d required v=1 d=1", sym_valid, sym_data);
    end
  endtask

  initial begin
    reset = 1'b1; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
    hc = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    m  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge clk);
    test_reset();
    test_decode();
    test_backpressure();
    test_error();
    test_reload_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
